// File: rtl/proc_pkg.sv
// Shared definitions for the fetch/issue stage and its controller: opcodes,
// fetch FSM state encodings and instruction-word field widths.
package proc_pkg;

    localparam int IR_W     = 9;
    localparam int OPCODE_W = 3;
    localparam int REG_W    = 3;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_MV   = 3'b000;
    localparam opcode_t OP_MVI  = 3'b001;
    localparam opcode_t OP_ADD  = 3'b010;
    localparam opcode_t OP_SUB  = 3'b011;
    localparam opcode_t OP_HALT = 3'b111;

    typedef logic [3:0] fetch_state_t;

    localparam fetch_state_t S_IDLE      = 4'd0;
    localparam fetch_state_t S_FETCH     = 4'd1;
    localparam fetch_state_t S_LOAD      = 4'd2;
    localparam fetch_state_t S_IMM_FETCH = 4'd3;
    localparam fetch_state_t S_IMM_LOAD  = 4'd4;
    localparam fetch_state_t S_ISSUE     = 4'd5;
    localparam fetch_state_t S_WAIT      = 4'd6;
    localparam fetch_state_t S_HALT      = 4'd7;
    localparam fetch_state_t S_ERR       = 4'd8;

    // Opcode lives in the top three bits of the IIIXXXYYY word.
    function automatic opcode_t ir_opcode(input logic [IR_W-1:0] word);
        return word[IR_W-1 -: OPCODE_W];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory bus plus the issue handshake towards the controller.
interface instr_fetch_if
    import proc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 9
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic [IR_W-1:0]   IR;
    logic [DATA_W-1:0] DIN;
    logic              run;
    logic              done;

    modport master (
        output mem_addr, mem_rd, IR, DIN, run,
        input  mem_rdata, done
    );

    modport slave (
        input  mem_addr, mem_rd, IR, DIN, run,
        output mem_rdata, done
    );
endinterface

// File: rtl/fetch_watchdog.sv
// Clearable cycle counter; terminal flags the cycle whose increment would
// reach TIMEOUT, so at most TIMEOUT enabled cycles pass before it fires.
module fetch_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TC_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && count_reg != TC_MAX) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign terminal = (count_reg == TC_LAST);
endmodule

// File: rtl/instr_fetch.sv
// Fetch/issue stage: walks the PC through synchronous instruction memory,
// hands each instruction (and mvi immediate) to the controller via run/done.
module instr_fetch
    import proc_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 9,
    parameter int START_ADDR = 0,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    instr_fetch_if.master     bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              error
);
    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [IR_W-1:0]   ir_reg, ir_next;
    logic [DATA_W-1:0] din_reg, din_next;
    logic              wd_clear, wd_enable, wd_terminal;

    fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wd_clear),
        .enable   (wd_enable),
        .terminal (wd_terminal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            pc_reg    <= START_PC;
            ir_reg    <= '0;
            din_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            din_reg   <= din_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        din_next   = din_reg;
        wd_clear   = 1'b0;
        wd_enable  = 1'b0;
        case (state_reg)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_next    = START_PC;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: state_next = S_LOAD;
            S_LOAD: begin
                ir_next = bus.mem_rdata[IR_W-1:0];
                pc_next = pc_reg + 1'b1;
                case (ir_opcode(bus.mem_rdata[IR_W-1:0]))
                    OP_HALT: state_next = S_HALT;
                    OP_MVI:  state_next = S_IMM_FETCH;
                    default: state_next = S_ISSUE;
                endcase
            end
            S_IMM_FETCH: state_next = S_IMM_LOAD;
            S_IMM_LOAD: begin
                // PC wraps modulo 2^ADDR_W, so an immediate may come from address 0.
                din_next   = bus.mem_rdata;
                pc_next    = pc_reg + 1'b1;
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                wd_clear   = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over an expiring watchdog in the same cycle.
                if (bus.done) begin
                    state_next = S_FETCH;
                end else begin
                    wd_enable = 1'b1;
                    if (wd_terminal) begin
                        state_next = S_ERR;
                    end
                end
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.mem_addr = pc_reg;
    assign bus.mem_rd   = (state_reg == S_FETCH) || (state_reg == S_IMM_FETCH);
    assign bus.run      = (state_reg == S_ISSUE);
    assign bus.IR       = ir_reg;
    assign bus.DIN      = din_reg;
    assign pc           = pc_reg;
    assign halted       = (state_reg == S_HALT);
    assign error        = (state_reg == S_ERR);
endmodule
